mib_round_robin_output_mux_8: RTL and testbench
===============================================

Name: mib_round_robin_output_mux_8

Overview:
- Many-to-one collector for the move protocol (move_to / move_valid / move_ack): 8 move buffers produce moves, one downstream consumer takes them.
- Round-robin arbitration across the 8 sources; the winner's payload goes into a one-entry registered output slot.
- Reports which buffer each output word came from. Sits between the move buffers and the shared move/network port, on the return side of the per-buffer instruction demux.

Parameters:
- MOVE_TO_W, 32, width of one move_to payload.
- NUM_IN, 8, number of source buffers; fixed at 8, must not be overridden.
- ADDR_W, 4, width of the source-address field (matches the move buffer address width).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous and active-high.
- in_move_to  input  NUM_IN*MOVE_TO_W  packed payloads; source i occupies bits [i*MOVE_TO_W +: MOVE_TO_W].
- in_move_valid  input  NUM_IN  per-source valid.
- in_move_ack  output  NUM_IN  per-source ack; combinational, one-hot or zero.
- out_move_to  output  MOVE_TO_W  registered payload.
- out_move_valid  output  1  registered valid.
- out_src_addr  output  ADDR_W  index of the source of out_move_to, zero-extended.
- out_move_ack  input  1  consumer accepts out_move_to this cycle.

Behaviour:
- Handshake: a transfer happens on a rising clk edge when valid and ack are both high in the same cycle, on each side.
- Sources may hold valid indefinitely and must keep payload stable until acked. The block never drops or duplicates a word.
- Slot state is derived from out_move_valid: EMPTY (0) or FULL (1).
- slot_free = !out_move_valid || out_move_ack (pass-through refill is allowed in the same cycle).
- Arbitration: each cycle, grant goes to the first asserted in_move_valid[j], scanning j = ptr, ptr+1, …, ptr+7 mod 8.
- in_move_ack[g] = slot_free && in_move_valid[g]; all other acks are 0. in_move_ack is 0 for every source when slot_free is 0.
- On a source transfer:
  - out_move_to <= payload[g].
  - out_src_addr <= g.
  - out_move_valid <= 1.
  - ptr <= (g+1) mod 8 (wraps 7 -> 0).
- Output accepted and no new grant in the same cycle: out_move_valid <= 0, payload and address hold.
- Output accepted and new grant in the same cycle: new word loaded, out_move_valid stays 1. This sustains 1 word/cycle.
- Latency: 1 cycle from source transfer to out_move_valid.
- No source valid: no ack, ptr unchanged.
- Only one source valid: it is granted every free cycle regardless of ptr.
- Downstream stall (out_move_valid=1, out_move_ack=0):
  - all in_move_ack=0;
  - ptr frozen;
  - output registers hold.
- Reset values:
  - out_move_valid=0
  - out_move_to=0
  - out_src_addr=0
  - ptr=0
- In-flight handling on reset:
  - rst mid-operation discards any slot contents.
  - in_move_ack is forced to 0 while rst=1, so no source word is consumed during reset.
- Fairness: a continuously valid source is granted within 8 free cycles.

Optional Feature:
- Macro: MIB_OUTPUT_MUX_STATS_EN.
- When defined, adds two ports:
  - stat_xfer_count  output 32: increments on every output-side transfer.
  - stat_stall_count  output 32: increments each cycle with out_move_valid=1 && out_move_ack=0.
- Both counters reset to 0, wrap modulo 2^32, and increment in the same cycle as the event.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst 3 cycles with all in_move_valid=8'hFF -> in_move_ack=0 throughout; after release out_move_valid=0, out_src_addr=0.
- Single source: in_move_valid=8'h08 with payload 32'hDEAD0003, out_move_ack=1 -> in_move_ack=8'h08 that cycle. Next cycle out_move_valid=1, out_move_to=32'hDEAD0003, out_src_addr=3.
- Round robin: all 8 valid, out_move_ack=1 constant, payload i = 32'h100+i -> output sequence src 0,1,…,7,0. One word per cycle, no bubbles.
- Backpressure: all valid, out_move_ack=0 for 5 cycles after the first word -> out_move_to held at 32'h100, in_move_ack=0. After out_move_ack=1, the next word is src 1 in the same cycle as the accept.
- Wrap and skip: ptr=7 (after granting src 6), in_move_valid=8'h05 -> src 0 granted, then src 2, then src 0.
- Mid-operation reset: out_move_valid=1 holding src 4 with out_move_ack=0, assert rst 1 cycle -> out_move_valid=0, ptr=0; src 4 word discarded; source 4 payload re-presented and later output once. With MIB_OUTPUT_MUX_STATS_EN defined, also check stat_xfer_count after the round-robin test = 9 and stat_stall_count after the backpressure test = 5.

Source files
------------

// File: rtl/mib_round_robin_output_mux_8.sv
// rtl/mib_round_robin_output_mux_8.sv - round-robin 8:1 move collector with a one-entry registered output slot
// Optional statistics counters are enabled by defining MIB_OUTPUT_MUX_STATS_EN.
module mib_round_robin_output_mux_8 #(
    parameter int MOVE_TO_W = 32,
    parameter int NUM_IN    = 8,
    parameter int ADDR_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN*MOVE_TO_W-1:0] in_move_to,
    input  logic [NUM_IN-1:0]           in_move_valid,
    output logic [NUM_IN-1:0]           in_move_ack,
    output logic [MOVE_TO_W-1:0]        out_move_to,
    output logic                        out_move_valid,
    output logic [ADDR_W-1:0]           out_src_addr,
    input  logic                        out_move_ack
`ifdef MIB_OUTPUT_MUX_STATS_EN
    ,
    output logic [31:0]                 stat_xfer_count,
    output logic [31:0]                 stat_stall_count
`endif
);

    localparam int IDX_W = 3;

    logic [MOVE_TO_W-1:0] payload [NUM_IN];
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     scan_idx;
    logic                 grant_valid;
    logic                 slot_free;
    logic                 xfer_in;
    logic                 xfer_out;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign payload[i] = in_move_to[i*MOVE_TO_W +: MOVE_TO_W];
    end

    // First valid source at or after ptr, wrapping modulo 8.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = ptr + k[IDX_W-1:0];
            if (!grant_valid && in_move_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign slot_free = !out_move_valid || out_move_ack;
    assign xfer_in   = !rst && slot_free && grant_valid;
    assign xfer_out  = out_move_valid && out_move_ack;

    always_comb begin
        in_move_ack = '0;
        if (xfer_in) begin
            in_move_ack[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_move_valid <= 1'b0;
            out_move_to    <= '0;
            out_src_addr   <= '0;
            ptr            <= '0;
        end else if (xfer_in) begin
            out_move_valid <= 1'b1;
            out_move_to    <= payload[grant_idx];
            out_src_addr   <= ADDR_W'(grant_idx);
            ptr            <= grant_idx + 1'b1;
        end else if (xfer_out) begin
            out_move_valid <= 1'b0;
        end
    end

`ifdef MIB_OUTPUT_MUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_xfer_count  <= '0;
            stat_stall_count <= '0;
        end else begin
            if (xfer_out) begin
                stat_xfer_count <= stat_xfer_count + 32'd1;
            end
            if (out_move_valid && !out_move_ack) begin
                stat_stall_count <= stat_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mib_round_robin_output_mux_8.sv
// tb/tb_mib_round_robin_output_mux_8.sv - scoreboard bench for the round-robin output mux
module tb_mib_round_robin_output_mux_8;

    logic         clk;
    logic         rst;
    logic [255:0] in_move_to;
    logic [7:0]   in_move_valid;
    logic [7:0]   in_move_ack;
    logic [31:0]  out_move_to;
    logic         out_move_valid;
    logic [3:0]   out_src_addr;
    logic         out_move_ack;
`ifdef MIB_OUTPUT_MUX_STATS_EN
    logic [31:0]  stat_xfer_count;
    logic [31:0]  stat_stall_count;
`endif

    logic [31:0] pay [8];

    typedef struct {
        logic [31:0] data;
        logic [3:0]  src;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    mib_round_robin_output_mux_8 dut (
        .clk            (clk),
        .rst            (rst),
        .in_move_to     (in_move_to),
        .in_move_valid  (in_move_valid),
        .in_move_ack    (in_move_ack),
        .out_move_to    (out_move_to),
        .out_move_valid (out_move_valid),
        .out_src_addr   (out_src_addr),
        .out_move_ack   (out_move_ack)
`ifdef MIB_OUTPUT_MUX_STATS_EN
        ,
        .stat_xfer_count  (stat_xfer_count),
        .stat_stall_count (stat_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_move_to = '0;
        for (int i = 0; i < 8; i++) in_move_to[i*32 +: 32] = pay[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        sb.push_back(e);
    endtask

    // Drive at posedge+1, check combinational at posedge+6, monitor at negedge.
    task automatic drive(input logic [7:0] v, input logic a);
        in_move_valid = v;
        out_move_ack  = a;
    endtask

    task automatic mid();
        #5;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'h00, 1'b0);
        next();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_move_valid && out_move_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {28'd0, out_src_addr}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_data", out_move_to, e.data);
                chk("mon_src", {28'd0, out_src_addr}, {28'd0, e.src});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) pay[i] = 32'h100 + i;
        rst = 1'b1;
        drive(8'hFF, 1'b0);
        #1;

        // Reset held 3 cycles with every source valid.
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("reset_ack", {24'd0, in_move_ack}, 32'h0);
            next();
        end
        rst = 1'b0;
        drive(8'h00, 1'b0);
        chk("reset_valid", {31'd0, out_move_valid}, 32'h0);
        chk("reset_src", {28'd0, out_src_addr}, 32'h0);
        chk("reset_data", out_move_to, 32'h0);

        // Single source.
        pay[3] = 32'hDEAD0003;
        drive(8'h08, 1'b1);
        push(32'hDEAD0003, 4'd3);
        mid();
        chk("single_ack", {24'd0, in_move_ack}, 32'h08);
        next();
        drive(8'h00, 1'b1);
        chk("single_valid", {31'd0, out_move_valid}, 32'h1);
        next();
        chk("single_drained", {31'd0, out_move_valid}, 32'h0);
        pay[3] = 32'h103;

        // Round robin, 9 grants from ptr=0.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(8'hFF, 1'b1);
            push(32'h100 + (k % 8), 4'(k % 8));
            mid();
            chk("rr_ack", {24'd0, in_move_ack}, 32'h1 << (k % 8));
            if (k > 0) chk("rr_nobubble", {31'd0, out_move_valid}, 32'h1);
            next();
        end
        drive(8'h00, 1'b1);
        next();
`ifdef MIB_OUTPUT_MUX_STATS_EN
        chk("stat_xfer", stat_xfer_count, 32'd9);
`endif

        // Backpressure after the first word.
        do_reset();
        drive(8'hFF, 1'b0);
        push(32'h100, 4'd0);
        push(32'h101, 4'd1);
        next();
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("bp_ack", {24'd0, in_move_ack}, 32'h0);
            chk("bp_hold", out_move_to, 32'h100);
            next();
        end
        drive(8'hFF, 1'b1);
        mid();
        chk("bp_release_ack", {24'd0, in_move_ack}, 32'h02);
`ifdef MIB_OUTPUT_MUX_STATS_EN
        chk("stat_stall", stat_stall_count, 32'd5);
`endif
        next();
        drive(8'h00, 1'b1);
        next();

        // Wrap and skip: grant 6 leaves ptr at 7.
        do_reset();
        drive(8'h40, 1'b1);
        push(32'h106, 4'd6);
        mid();
        chk("wrap_ack6", {24'd0, in_move_ack}, 32'h40);
        next();
        drive(8'h05, 1'b1);
        push(32'h100, 4'd0);
        mid();
        chk("wrap_ack0", {24'd0, in_move_ack}, 32'h01);
        next();
        push(32'h102, 4'd2);
        mid();
        chk("skip_ack2", {24'd0, in_move_ack}, 32'h04);
        next();
        push(32'h100, 4'd0);
        mid();
        chk("wrap_ack0b", {24'd0, in_move_ack}, 32'h01);
        next();
        drive(8'h00, 1'b1);
        next();

        // Mid-operation reset discards the stalled src 4 word.
        do_reset();
        drive(8'h10, 1'b0);
        mid();
        chk("mr_ack", {24'd0, in_move_ack}, 32'h10);
        next();
        mid();
        chk("mr_stall_ack", {24'd0, in_move_ack}, 32'h0);
        chk("mr_stall_valid", {31'd0, out_move_valid}, 32'h1);
        next();
        rst = 1'b1;
        mid();
        chk("mr_rst_ack", {24'd0, in_move_ack}, 32'h0);
        next();
        rst = 1'b0;
        chk("mr_cleared", {31'd0, out_move_valid}, 32'h0);
        drive(8'h10, 1'b1);
        push(32'h104, 4'd4);
        mid();
        chk("mr_regrant", {24'd0, in_move_ack}, 32'h10);
        next();
        drive(8'h00, 1'b1);
        next();
        chk("mr_once", {31'd0, out_move_valid}, 32'h0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
